// File: rtl/bit_stream_pkg.sv
// Shared definitions for the bit-serial operand transmitter.
// Holds the controller state encoding and the default operand width.
package bit_stream_pkg;

    localparam int BS_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } bs_state_t;

endpackage

// File: rtl/bs_piso.sv
// Two-lane parallel-in serial-out shift register.
// Both lanes load together and shift right together, filling with zeros, so
// once a word has been fully sent the lane outputs settle at 0 on their own.
module bs_piso
    import bit_stream_pkg::*;
#(
    parameter int WIDTH = BS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic             lane_a,
    output logic             lane_b
);

    logic [WIDTH-1:0] sreg_a;
    logic [WIDTH-1:0] sreg_b;

    // Load a fresh operand pair, otherwise move both lanes one bit toward the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_a <= '0;
            sreg_b <= '0;
        end else if (load) begin
            sreg_a <= load_a;
            sreg_b <= load_b;
        end else if (shift) begin
            sreg_a <= {1'b0, sreg_a[WIDTH-1:1]};
            sreg_b <= {1'b0, sreg_b[WIDTH-1:1]};
        end
    end

    assign lane_a = sreg_a[0];
    assign lane_b = sreg_b[0];

endmodule

// File: rtl/bit_stream_operand_tx.sv
// Serialises operand pairs LSB-first onto the A/B inputs of a bit-serial adder.
// sof marks bit 0 so the adder can clear its carry; eof marks the word's last cycle.
// Optional feature: define BSTX_CARRY_FLUSH_EN to append one zero-operand FLUSH
// cycle per word, letting the adder emit its final carry as sum bit WIDTH.
module bit_stream_operand_tx
    import bit_stream_pkg::*;
#(
    parameter int WIDTH = BS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             A,
    output logic             B,
    output logic             bit_valid,
    output logic             sof,
    output logic             eof
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    bs_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          ready_decode;
    logic          accept;
    logic          shift;

    assign cnt_inc = cnt + CW'(1);
    assign accept  = in_valid & in_ready;
    assign shift   = (state == SHIFT) & ~accept;

    // Ready in IDLE and in the final cycle of a word; forced low while reset is held.
    always_comb begin
        ready_decode = 1'b0;
`ifdef BSTX_CARRY_FLUSH_EN
        ready_decode = (state == IDLE) || (state == FLUSH);
`else
        ready_decode = (state == IDLE) || ((state == SHIFT) && (cnt == LAST));
`endif
    end

    assign in_ready = rst_n & ready_decode;

    // Word controller: tracks the bit position and registers the framing flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        bit_valid <= 1'b1;
                        sof       <= 1'b1;
                        eof       <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
`ifdef BSTX_CARRY_FLUSH_EN
                        state     <= FLUSH;
                        cnt       <= '0;
                        bit_valid <= 1'b1;
                        sof       <= 1'b0;
                        eof       <= 1'b1;
`else
                        if (accept) begin
                            state     <= SHIFT;
                            cnt       <= '0;
                            bit_valid <= 1'b1;
                            sof       <= 1'b1;
                            eof       <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            cnt       <= '0;
                            bit_valid <= 1'b0;
                            sof       <= 1'b0;
                            eof       <= 1'b0;
                        end
`endif
                    end else begin
                        cnt       <= cnt_inc;
                        bit_valid <= 1'b1;
                        sof       <= 1'b0;
`ifdef BSTX_CARRY_FLUSH_EN
                        eof       <= 1'b0;
`else
                        eof       <= (cnt_inc == LAST);
`endif
                    end
                end
`ifdef BSTX_CARRY_FLUSH_EN
                FLUSH: begin
                    cnt <= '0;
                    if (accept) begin
                        state     <= SHIFT;
                        bit_valid <= 1'b1;
                        sof       <= 1'b1;
                        eof       <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        bit_valid <= 1'b0;
                        sof       <= 1'b0;
                        eof       <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    bit_valid <= 1'b0;
                    sof       <= 1'b0;
                    eof       <= 1'b0;
                end
            endcase
        end
    end

    bs_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .shift  (shift),
        .load_a (op_a),
        .load_b (op_b),
        .lane_a (A),
        .lane_b (B)
    );

endmodule

// File: tb/tb_bit_stream_operand_tx.sv
// Testbench for bit_stream_operand_tx at WIDTH=4.
// A queue of expected per-cycle outputs is filled word by word whenever the
// model decides a pair is accepted; every cycle is compared against it.
// Build with BSTX_CARRY_FLUSH_EN defined to exercise the carry flush cycle.
module tb_bit_stream_operand_tx;

    localparam int W = 4;
`ifdef BSTX_CARRY_FLUSH_EN
    localparam int FLUSH_MODE = 1;
`else
    localparam int FLUSH_MODE = 0;
`endif
    localparam int WORD_CYC = W + FLUSH_MODE;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready;
    logic         A;
    logic         B;
    logic         bit_valid;
    logic         sof;
    logic         eof;

    int total = 0;
    int bad   = 0;

    logic [4:0] exp_q[$];

    int         bv_cnt  = 0;
    int         sof_cnt = 0;
    int         eof_cnt = 0;
    logic [7:0] a_hist  = '0;
    logic [7:0] b_hist  = '0;
    logic [4:0] y_hist  = '0;
    logic       carry   = 1'b0;

    bit_stream_operand_tx #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .A         (A),
        .B         (B),
        .bit_valid (bit_valid),
        .sof       (sof),
        .eof       (eof)
    );

    always #5 clk = ~clk;

    // Count a comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        in_valid = v;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, W'($urandom), W'($urandom));
    endtask

    // Expected cycles of one word: {A, B, bit_valid, sof, eof}.
    task automatic pushWord(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < W; i++)
            exp_q.push_back({a[i], b[i], 1'b1, (i == 0), (FLUSH_MODE == 0) && (i == W - 1)});
        if (FLUSH_MODE != 0)
            exp_q.push_back(5'b00101);
    endtask

    // Mid-cycle monitor: compare against the model, decide acceptance, record stats.
    always @(negedge clk) begin
        logic [4:0] e;
        logic       exp_ready;
        logic       cin;
        logic       y;
        if (!rst_n) begin
            exp_q.delete();
            checkOutput("reset_outputs", {58'd0, in_ready, A, B, bit_valid, sof, eof}, 64'd0);
        end else begin
            e = 5'b0;
            if (exp_q.size() > 0)
                e = exp_q.pop_front();
            exp_ready = (exp_q.size() == 0);
            checkOutput("bit_outputs", {59'd0, A, B, bit_valid, sof, eof}, {59'd0, e});
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
            if (in_valid && exp_ready)
                pushWord(op_a, op_b);
            if (bit_valid) begin
                bv_cnt++;
                if (sof) sof_cnt++;
                if (eof) eof_cnt++;
                if (!(FLUSH_MODE != 0 && eof)) begin
                    a_hist = {A, a_hist[7:1]};
                    b_hist = {B, b_hist[7:1]};
                end
                cin    = sof ? 1'b0 : carry;
                y      = A ^ B ^ cin;
                carry  = (A & B) | (A & cin) | (B & cin);
                y_hist = {y, y_hist[4:1]};
            end
        end
    end

    initial begin
        int bv0;
        int sof0;
        int eof0;

        // Hold reset for a few cycles, then release just after an edge.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle hold: nothing offered for 10 cycles.
        bv0 = bv_cnt;
        idleCycles(10);
        @(negedge clk);
        checkOutput("idle_hold_bv", 64'(bv_cnt - bv0), 64'd0);

        // Basic transfer.
        bv0 = bv_cnt; sof0 = sof_cnt; eof0 = eof_cnt;
        applyStimulus(1'b1, 4'b0110, 4'b0011);
        idleCycles(WORD_CYC + 3);
        checkOutput("basic_a_bits", {56'd0, a_hist[7:4]}, 64'h6);
        checkOutput("basic_b_bits", {56'd0, b_hist[7:4]}, 64'h3);
        checkOutput("basic_bv_count", 64'(bv_cnt - bv0), 64'(WORD_CYC));
        checkOutput("basic_sof_count", 64'(sof_cnt - sof0), 64'd1);
        checkOutput("basic_eof_count", 64'(eof_cnt - eof0), 64'd1);

        // Back-to-back words with in_valid held.
        bv0 = bv_cnt; sof0 = sof_cnt; eof0 = eof_cnt;
        applyStimulus(1'b1, 4'hF, 4'h1);
        for (int i = 0; i < WORD_CYC; i++)
            applyStimulus(1'b1, 4'h0, 4'hA);
        idleCycles(WORD_CYC + 3);
        checkOutput("b2b_a_bits", {56'd0, a_hist}, 64'h0F);
        checkOutput("b2b_b_bits", {56'd0, b_hist}, 64'hA1);
        checkOutput("b2b_bv_count", 64'(bv_cnt - bv0), 64'(2 * WORD_CYC));
        checkOutput("b2b_sof_count", 64'(sof_cnt - sof0), 64'd2);
        checkOutput("b2b_eof_count", 64'(eof_cnt - eof0), 64'd2);

        // Backpressure: a new pair offered during the second cycle of a word.
        applyStimulus(1'b1, 4'h9, 4'h5);
        applyStimulus(1'b0, 4'h2, 4'h7);
        for (int i = 0; i < WORD_CYC - 1; i++)
            applyStimulus(1'b1, 4'hC, 4'h3);
        idleCycles(WORD_CYC + 3);
        checkOutput("bp_a_bits", {56'd0, a_hist}, 64'hC9);
        checkOutput("bp_b_bits", {56'd0, b_hist}, 64'h35);

`ifdef BSTX_CARRY_FLUSH_EN
        // Carry flush: F + 1 through the bench's serial adder gives 0,0,0,0,1.
        applyStimulus(1'b1, 4'hF, 4'h1);
        idleCycles(WORD_CYC + 3);
        checkOutput("flush_sum_bits", {59'd0, y_hist}, 64'h10);
`endif

        // Reset asserted in the middle of a word.
        eof0 = eof_cnt;
        applyStimulus(1'b1, 4'hB, 4'hE);
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", {58'd0, in_ready, A, B, bit_valid, sof, eof}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bv0 = bv_cnt;
        idleCycles(WORD_CYC + 2);
        checkOutput("post_reset_bv", 64'(bv_cnt - bv0), 64'd0);
        checkOutput("post_reset_eof", 64'(eof_cnt - eof0), 64'd0);

        // Randomised traffic, operands changing every cycle.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 2) != 0, W'($urandom), W'($urandom));
        idleCycles(WORD_CYC + 3);
        checkOutput("drain_queue", 64'(exp_q.size()), 64'd0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_stream_operand_tx.md
BIT_STREAM_OPERAND_TX -- requirements
Module: bit_stream_operand_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand word length in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-006 The block SHALL have port op_a, input, WIDTH bits: parallel operand A.
REQ-007 The block SHALL have port op_b, input, WIDTH bits: parallel operand B.
REQ-008 The block SHALL have port A, output, 1 bit: serial operand A bit, for direct connection to the adder's A input.
REQ-009 The block SHALL have port B, output, 1 bit: serial operand B bit, for direct connection to the adder's B input.
REQ-010 The block SHALL have port bit_valid, output, 1 bit: A and B carry a live bit this cycle.
REQ-011 The block SHALL have port sof, output, 1 bit: the current bit is bit 0 of a word, used downstream to clear the carry.
REQ-012 The block SHALL have port eof, output, 1 bit: the current bit is the last bit of a word.

Function
REQ-013 The block SHALL implement the states IDLE, SHIFT and FLUSH, with FLUSH present only under REQ-027.
REQ-014 An operand pair SHALL be accepted on a rising edge where in_valid and in_ready are both 1; op_a and op_b are captured into shift registers at that edge.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in the final cycle of a word (the last SHIFT cycle, or the FLUSH cycle when FLUSH is present), and 0 otherwise.
REQ-016 Latency SHALL be one cycle: bit 0 appears on A and B in the cycle immediately after the accepting edge.
REQ-017 Bits SHALL be sent LSB-first, one bit per cycle, with bit_valid equal to 1 for each of the WIDTH bit cycles.
REQ-018 sof SHALL be 1 only in the bit-0 cycle, and eof SHALL be 1 only in the last cycle of the word.
REQ-019 On acceptance in the final cycle of a word, the next word SHALL start the following cycle with no gap and no bit_valid bubble.
REQ-020 When no new pair is accepted in the final cycle, the block SHALL return to IDLE, where A=0, B=0, bit_valid=0, sof=0 and eof=0.
REQ-021 The bit counter SHALL be $clog2(WIDTH+1) bits wide, count 0..WIDTH-1, and never wrap past WIDTH-1.
REQ-022 Changes on op_a, op_b or in_valid outside an accepting edge SHALL have no effect on the word in flight.
REQ-023 All outputs except in_ready SHALL be driven from registers; in_ready is a combinational decode of state and counter.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE, the counter and shift registers 0, and A, B, bit_valid, sof, eof and in_ready all 0.
REQ-025 A reset asserted mid-word SHALL abandon the word immediately: no eof is issued and no bits are resumed after deassertion.
REQ-026 in_ready SHALL become 1 in the first cycle after rst_n rises.

Configuration
REQ-027 When macro BSTX_CARRY_FLUSH_EN is defined, each word SHALL be followed by one FLUSH cycle with A=0, B=0, bit_valid=1 and eof=1 (eof not asserted on bit WIDTH-1), so the adder emits its final carry as sum bit WIDTH.
REQ-028 When BSTX_CARRY_FLUSH_EN is undefined, the FLUSH state and its logic SHALL be absent, and a word SHALL occupy exactly WIDTH cycles.

Structure
REQ-029 Package bit_stream_pkg SHALL hold the state enum (IDLE/SHIFT/FLUSH) and the constant BS_DEFAULT_WIDTH=8.
REQ-030 Sub-module bs_piso SHALL implement the two-lane parallel-in serial-out shift register (load, shift, lane outputs); the FSM and counter stay in the top module.

Verification
REQ-031 The bench SHALL cover basic transfer: WIDTH=4, accept op_a=4'b0110 and op_b=4'b0011 -> A=0,1,1,0 and B=1,1,0,0 on the next 4 cycles; sof on cycle 1; eof on cycle 4; then idle.
REQ-032 The bench SHALL cover back-to-back words: with in_valid held, pairs (4'hF,4'h1) then (4'h0,4'hA) -> 8 contiguous bit_valid cycles; sof on cycles 1 and 5; eof on cycles 4 and 8.
REQ-033 The bench SHALL cover backpressure: in_valid asserted during cycle 2 of a word -> in_ready=0 and no capture until the eof cycle; the new word starts the next cycle.
REQ-034 The bench SHALL cover reset mid-word: rst_n=0 during bit 2 -> all outputs 0 asynchronously; after release, in_ready=1 and no residual bits or eof appear.
REQ-035 The bench SHALL cover carry flush with BSTX_CARRY_FLUSH_EN defined and WIDTH=4: op_a=4'hF, op_b=4'h1 -> 5 bit_valid cycles; cycle 5 has A=0, B=0, eof=1; the connected adder's Y reads 0,0,0,0,1.
REQ-036 The bench SHALL cover the idle hold: in_valid=0 for 10 cycles after reset -> bit_valid=0 and A=B=0 throughout.
